// File: rtl/pixel_streamer_pkg.sv
// pixel_streamer_pkg: shared state encoding, pixel width and frame constants for the streamer.
package pixel_streamer_pkg;
  localparam int PIX_W = 8;
  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;
  localparam int FRAME_PIX = DEF_IMG_W * DEF_IMG_H;
  localparam int READ_LAT = 1;
  typedef enum logic [1:0] {IDLE, STREAM, BLANK, DRAIN} state_e;
  function automatic int frame_pix(input int w, input int h);
    return w * h;
  endfunction
endpackage

// File: rtl/pixel_streamer_raster_counter.sv
// raster_counter: row/col/linear address counters advancing on en_i, with last-column and last-pixel flags.
module raster_counter
  import pixel_streamer_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int ADDR_W = 12,
  parameter int NPIX = FRAME_PIX,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [RW-1:0]     row_o,
  output logic [CW-1:0]     col_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_col_o,
  output logic              last_pix_o
);
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic wrap;
  assign last_col_o = col_q == CW'(IMG_W - 1);
  assign last_pix_o = addr_q == ADDR_W'(NPIX - 1);
  assign wrap = clr_i || (en_i && last_pix_o);
  assign row_o = row_q;
  assign col_o = col_q;
  assign addr_o = addr_q;
  always_comb begin
    col_d = clr_i || (en_i && last_col_o) ? '0 : col_q + CW'(en_i);
    row_d = wrap ? '0 : row_q + RW'(en_i && last_col_o);
    addr_d = wrap ? '0 : addr_q + ADDR_W'(en_i);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
      addr_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      addr_q <= addr_d;
    end
endmodule

// File: rtl/pixel_streamer.sv
// pixel_streamer: raster-order frame source reading a sync frame RAM onto the pixel/pixel_valid stream.
// Define PIXEL_STREAMER_PATTERN_EN to add pattern_mode, which replaces RAM data with row^col.
module pixel_streamer
  import pixel_streamer_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int ADDR_W = 12,
  parameter int HBLANK = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
`ifdef PIXEL_STREAMER_PATTERN_EN
  input  logic              pattern_mode,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pixel,
  output logic              pixel_valid,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);
  localparam int NPIX = frame_pix(IMG_W, IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [7:0] BLK_LAST = 8'(HBLANK > 0 ? HBLANK - 1 : 0);
  localparam logic [1:0] DRN_LAST = 2'(READ_LAT + 1);
  state_e state_q, state_d;
  logic [7:0] blank_q, blank_d;
  logic [1:0] drain_q, drain_d;
  logic done_q, done_d, pat_q, pat_d, clr, issue, last_col, last_pix;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic v1_q, sof1_q, eol1_q, eof1_q, pv_q, sof_q, eol_q, eof_q;
  logic [PIX_W-1:0] pat1_q, pixel_q;
  assign issue = state_q == STREAM && !pause;
  assign mem_rd_en = issue && !pat_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign pixel = pixel_q;
  assign pixel_valid = pv_q;
  assign sof = sof_q;
  assign eol = eol_q;
  assign eof = eof_q;
`ifdef PIXEL_STREAMER_PATTERN_EN
  assign pat_d = state_q == IDLE && start ? pattern_mode : pat_q;
`else
  assign pat_d = 1'b0;
`endif
  raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .NPIX(NPIX)) u_cnt (
    .clk(clk), .reset(reset), .clr_i(clr), .en_i(issue),
    .row_o(row), .col_o(col), .addr_o(mem_addr),
    .last_col_o(last_col), .last_pix_o(last_pix)
  );
  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    drain_d = drain_q;
    clr = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = STREAM;
        clr = 1'b1;
      end
      STREAM: if (issue && last_pix) begin
        state_d = DRAIN;
        drain_d = '0;
      end else if (issue && last_col && HBLANK > 0) begin
        state_d = BLANK;
        blank_d = '0;
      end
      BLANK: if (!pause) begin
        if (blank_q == BLK_LAST) state_d = STREAM;
        blank_d = blank_q + 8'd1;
      end
      DRAIN: begin
        if (drain_q == DRN_LAST) state_d = IDLE;
        done_d = drain_q == DRN_LAST;
        drain_d = drain_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Markers and pattern value travel one stage alongside the RAM read, then land with the pixel.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      blank_q <= '0;
      drain_q <= '0;
      done_q <= 1'b0;
      pat_q <= 1'b0;
      v1_q <= 1'b0;
      sof1_q <= 1'b0;
      eol1_q <= 1'b0;
      eof1_q <= 1'b0;
      pat1_q <= '0;
      pv_q <= 1'b0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      eof_q <= 1'b0;
      pixel_q <= '0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
      drain_q <= drain_d;
      done_q <= done_d;
      pat_q <= pat_d;
      v1_q <= issue;
      sof1_q <= issue && mem_addr == '0;
      eol1_q <= issue && last_col;
      eof1_q <= issue && last_pix;
      pat1_q <= PIX_W'(row) ^ PIX_W'(col);
      pv_q <= v1_q;
      sof_q <= sof1_q;
      eol_q <= eol1_q;
      eof_q <= eof1_q;
      if (v1_q) pixel_q <= pat_q ? pat1_q : mem_rdata;
    end
endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer: two streamers (HBLANK 0 and 2) on shared stimulus, each with a frame-level reference model and scoreboard.
module tb_pixel_streamer;
  localparam int W = 4, H = 3, N = W * H, AW = 12;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, pat_mode = 1'b0;
  int cyc = 0, checks = 0, failures = 0, p_lo = -1, p_hi = -2;
  logic [7:0] ram [N];
  typedef struct {logic [7:0] pix; logic sof, eol, eof; int t;} exp_t;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, req);
    end
  endfunction
  function automatic bit paused(input int c);
    return c >= p_lo && c <= p_hi;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int HB = 2 * g;
    logic rd_en, pv, so, eo, ef, busy, done;
    logic [AW-1:0] addr;
    logic [7:0] rdata = 8'd0, pix;
    exp_t q[$];
    int dq[$];
    int idle_at = 0, b_lo = 0, b_hi = -1, pushed = 0, popped = 0;
    pixel_streamer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .HBLANK(HB)) dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause),
`ifdef PIXEL_STREAMER_PATTERN_EN
      .pattern_mode(pat_mode),
`endif
      .mem_rd_en(rd_en), .mem_addr(addr), .mem_rdata(rdata),
      .pixel(pix), .pixel_valid(pv), .sof(so), .eol(eo), .eof(ef),
      .busy(busy), .done(done)
    );
    always @(posedge clk) if (rd_en) rdata <= ram[int'(addr) % N];
    // Model: each accepted start yields the whole frame's pixels with their due cycles, from the pause window and blanking rule.
    always @(negedge clk) begin
      int c, last;
      exp_t e;
      if (!reset) begin
        q.delete();
        dq.delete();
        pushed = popped;
        idle_at = cyc + 1;
        b_hi = -1;
      end else if (start && cyc >= idle_at) begin
        c = cyc + 1;
        last = c;
        b_lo = cyc + 1;
        for (int i = 0; i < N; i++) begin
          while (paused(c)) c++;
          e.pix = pat_mode ? 8'((i / W) ^ (i % W)) : ram[i];
          e.sof = i == 0;
          e.eol = i % W == W - 1;
          e.eof = i == N - 1;
          e.t = c + 2;
          q.push_back(e);
          last = c;
          c++;
          if (i % W == W - 1 && i < N - 1)
            for (int b = 0; b < HB; b++) begin
              while (paused(c)) c++;
              c++;
            end
        end
        dq.push_back(last + 4);
        idle_at = last + 4;
        b_hi = last + 3;
        pushed += N + 1;
      end
    end
    always @(negedge clk) begin
      exp_t e;
      if (!reset) chk($sformatf("hb%0d_reset_outputs", HB), int'({rd_en, pv, so, eo, ef, busy, done, pix, addr}), 0);
      else begin
        chk($sformatf("hb%0d_busy", HB), int'(busy), int'(cyc >= b_lo && cyc <= b_hi));
        chk($sformatf("hb%0d_marker_without_valid", HB), int'((so | eo | ef) & ~pv), 0);
        if (pause || pat_mode) chk($sformatf("hb%0d_rd_en_blocked", HB), int'(rd_en), 0);
        if (pv && q.size() == 0) chk($sformatf("hb%0d_spurious_pixel_valid", HB), int'(pv), 0);
        else if (pv) begin
          e = q.pop_front();
          popped++;
          chk($sformatf("hb%0d_pixel", HB), int'(pix), int'(e.pix));
          chk($sformatf("hb%0d_markers_sof_eol_eof", HB), int'({so, eo, ef}), int'({e.sof, e.eol, e.eof}));
          chk($sformatf("hb%0d_valid_cycle", HB), cyc, e.t);
        end
        if (done && dq.size() == 0) chk($sformatf("hb%0d_spurious_done", HB), int'(done), 0);
        else if (done) begin
          popped++;
          chk($sformatf("hb%0d_done_cycle", HB), cyc, dq.pop_front());
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pause = paused(cyc);
    end
  endtask
  task automatic wait_idle();
    int k = 0;
    while (k < 400 && (inst[0].pushed != inst[0].popped || inst[1].pushed != inst[1].popped)) begin
      tick(1);
      k++;
    end
    chk("outstanding_expectations", (inst[0].pushed - inst[0].popped) + (inst[1].pushed - inst[1].popped), 0);
    tick(3);
  endtask
  task automatic run_frame(input int hold, input int plo, input int plen);
    p_lo = cyc + plo;
    p_hi = cyc + plo + plen - 1;
    start = 1'b1;
    tick(hold);
    start = 1'b0;
    wait_idle();
  endtask
  initial begin
    #1 reset = 1'b0;
    for (int i = 0; i < N; i++) ram[i] = 8'(i);
    tick(3);
    reset = 1'b1;
    tick(2);
    run_frame(1, 1, 0);
    run_frame(1, 5, 3);
    for (int i = 0; i < N; i++) ram[i] = 8'($urandom);
    p_lo = -1;
    p_hi = -2;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(7);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(6);
    run_frame(1, 1, 0);
    run_frame(16, 1, 0);
    run_frame(23, 2, 2);
`ifdef PIXEL_STREAMER_PATTERN_EN
    pat_mode = 1'b1;
    run_frame(1, 1, 0);
    pat_mode = 1'b0;
`endif
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) ram[i] = 8'($urandom);
      run_frame(int'($urandom_range(1, 25)), int'($urandom_range(1, 15)), int'($urandom_range(0, 4)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
